// File: rtl/companion_animator.sv
// companion_animator: plays idle/sick loops and fixed-length action animations,
// answering the companion menu's exec request with a four-phase exec_status handshake.
module companion_animator #(
  parameter int CLOCK_FREQ     = 125_000_000,
  parameter int FRAME_TICKS    = CLOCK_FREQ / 8,
  parameter int ACTION_FRAMES  = 8,
  parameter int IDLE_FRAMES    = 4,
  parameter int SICK_THRESHOLD = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exec,
  input  logic [1:0]  selected,
  input  logic        menu_open,
  input  logic [31:0] health,
  output logic        exec_status,
  output logic        busy,
  output logic [2:0]  anim_id,
  output logic [3:0]  frame,
  output logic        frame_tick
);
  localparam int CW = FRAME_TICKS > 1 ? $clog2(FRAME_TICKS) : 1;
  // START is the one-cycle gap between sampling exec and raising busy
  typedef enum logic [1:0] {IDLE, START, PLAY, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] act, act_n;
  logic [2:0] anim_n, idle_id;
  logic [3:0] frame_n;
  logic run, tick, moving;
  assign idle_id = health < $unsigned(SICK_THRESHOLD) ? 3'd4 : 3'd0;
  assign run = state == PLAY || (state == IDLE && !menu_open);
  assign tick = run && cnt == CW'(FRAME_TICKS - 1);
  assign moving = state_n != state;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = exec ? (selected != 2'b00 ? START : DONE) : IDLE;
      START:   state_n = PLAY;
      PLAY:    state_n = tick && frame == 4'(ACTION_FRAMES - 1) ? DONE : PLAY;
      DONE:    state_n = exec ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // the tick counter restarts on every state change so first frames are full length
  always_comb begin
    act_n = state == IDLE && state_n == START ? selected : act;
    cnt_n = moving || tick ? '0 : run ? cnt + 1'b1 : cnt;
    anim_n = anim_id;
    frame_n = frame;
    case (state)
      IDLE: if (!moving) begin
        anim_n = idle_id;
        frame_n = idle_id != anim_id ? 4'd0 :
                  tick ? (frame == 4'(IDLE_FRAMES - 1) ? 4'd0 : frame + 4'd1) : frame;
      end
      START: begin
        anim_n = {1'b0, act};
        frame_n = 4'd0;
      end
      PLAY: if (tick && !moving) frame_n = frame + 4'd1;
      DONE: if (moving) begin
        anim_n = idle_id;
        frame_n = 4'd0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      act <= 2'b00;
      anim_id <= 3'd0;
      frame <= 4'd0;
      busy <= 1'b0;
      exec_status <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cnt <= cnt_n;
      act <= act_n;
      anim_id <= anim_n;
      frame <= frame_n;
      busy <= state_n == PLAY;
      exec_status <= state_n == DONE;
      frame_tick <= tick;
    end
  end
endmodule

// File: tb/tb_companion_animator.sv
// tb_companion_animator: randomized checks of companion_animator against a
// cycle-count model of the idle loop and the action handshake.
module tb_companion_animator;
  localparam int FT = 4, AF = 3, IF = 2, ST = 25;
  logic clk = 0, rst = 1, exec = 0, menu_open = 0;
  logic [1:0] selected = 2'b00;
  logic [31:0] health = 100;
  logic exec_status, busy, frame_tick;
  logic [2:0] anim_id;
  logic [3:0] frame;
  int checks = 0, passed = 0;
  int e = 0, fbase = 0;
  logic [2:0] exp_anim = 3'd0;

  companion_animator #(
    .CLOCK_FREQ(32), .FRAME_TICKS(FT), .ACTION_FRAMES(AF),
    .IDLE_FRAMES(IF), .SICK_THRESHOLD(ST)
  ) dut (
    .clk(clk), .rst(rst), .exec(exec), .selected(selected),
    .menu_open(menu_open), .health(health), .exec_status(exec_status),
    .busy(busy), .anim_id(anim_id), .frame(frame), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] idle_of(input logic [31:0] h);
    return h < ST ? 3'd4 : 3'd0;
  endfunction

  // idle model: e counts unfrozen idle cycles, frames advance every FT of them
  task automatic reset_model;
    e = 0;
    fbase = 0;
    exp_anim = idle_of(health);
  endtask

  task automatic idle_step;
    bit running;
    int ef;
    logic [9:0] got, expv;
    running = !menu_open;
    step;
    if (running) e++;
    if (idle_of(health) != exp_anim) begin
      exp_anim = idle_of(health);
      fbase = e / FT;
    end
    ef = (e / FT - fbase) % IF;
    expv = {exp_anim, 4'(ef), running && (e % FT == 0), 1'b0, 1'b0};
    got = {anim_id, frame, frame_tick, busy, exec_status};
    checks++;
    if (got !== expv) $display("FAIL idle_step t=%0t {anim,frame,tick,busy,status} got %b exp %b", $time, got, expv);
    else passed++;
  endtask

  task automatic run_action(input logic [1:0] s, input bit hold, input int linger);
    logic [2:0] da;
    logic [3:0] df;
    logic [8:0] got, expv;
    da = (s == 2'b00) ? exp_anim : {1'b0, s};
    df = (s == 2'b00) ? 4'((e / FT - fbase) % IF) : 4'(AF - 1);
    exec = 1;
    selected = s;
    step;
    checks++;
    if ({busy, exec_status} !== {1'b0, s == 2'b00}) $display("FAIL accept sel=%0d {busy,status} got %b exp %b", s, {busy, exec_status}, {1'b0, s == 2'b00});
    else passed++;
    if (!hold) exec = 0;
    if (s != 2'b00) begin
      for (int k = 0; k < AF * FT; k++) begin
        step;
        got = {busy, exec_status, anim_id, frame};
        expv = {2'b10, 1'b0, s, 4'(k / FT)};
        checks++;
        if (got !== expv) $display("FAIL play sel=%0d k=%0d {busy,status,anim,frame} got %b exp %b", s, k, got, expv);
        else passed++;
        selected = 2'($urandom);
      end
      step;
      got = {busy, exec_status, anim_id, frame};
      expv = {2'b01, da, df};
      checks++;
      if (got !== expv) $display("FAIL done_entry sel=%0d got %b exp %b", s, got, expv);
      else passed++;
    end
    if (hold) for (int i = 0; i < linger; i++) begin
      selected = 2'($urandom);
      step;
      got = {busy, exec_status, anim_id, frame};
      expv = {2'b01, da, df};
      checks++;
      if (got !== expv) $display("FAIL done_hold sel=%0d i=%0d got %b exp %b", s, i, got, expv);
      else passed++;
    end
    exec = 0;
    step;
    got = {busy, exec_status, anim_id, frame};
    expv = {2'b00, idle_of(health), 4'd0};
    checks++;
    if (got !== expv) $display("FAIL release sel=%0d got %b exp %b", s, got, expv);
    else passed++;
    reset_model;
  endtask

  task automatic test_reset;
    #2 rst = 0;
    #1;
    checks++;
    if ({exec_status, busy, anim_id, frame, frame_tick} !== 10'b0) $display("FAIL reset_async got %b exp 0", {exec_status, busy, anim_id, frame, frame_tick});
    else passed++;
    repeat (3) begin
      exec = 1;
      selected = 2'b10;
      step;
      checks++;
      if ({exec_status, busy, anim_id, frame, frame_tick} !== 10'b0) $display("FAIL reset_hold got %b exp 0", {exec_status, busy, anim_id, frame, frame_tick});
      else passed++;
    end
    exec = 0;
    selected = 2'b00;
    rst = 1;
    reset_model;
  endtask

  task automatic test_idle;
    repeat (20) idle_step;
  endtask

  task automatic test_action_held;
    run_action(2'b10, 1'b1, 3);
    repeat (5) idle_step;
  endtask

  task automatic test_action_pulse;
    run_action(2'b01, 1'b0, 0);
    repeat (3) idle_step;
  endtask

  task automatic test_health_menu;
    repeat (3) idle_step;
    health = 24;
    idle_step;
    checks++;
    if ({anim_id, frame} !== {3'd4, 4'd0}) $display("FAIL sick_entry {anim,frame} got %b exp %b", {anim_id, frame}, {3'd4, 4'd0});
    else passed++;
    repeat (5) idle_step;
    menu_open = 1;
    repeat (10) idle_step;
    menu_open = 0;
    repeat (6) idle_step;
    health = 25;
    idle_step;
    checks++;
    if (anim_id !== 3'd0) $display("FAIL sick_exit anim got %0d exp 0", anim_id);
    else passed++;
    repeat (4) idle_step;
  endtask

  task automatic test_zero_action;
    run_action(2'b00, 1'b1, 2);
    repeat (3) idle_step;
    run_action(2'b00, 1'b0, 0);
    repeat (2) idle_step;
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 8; n++) begin
      health = $urandom_range(1, 0) ? 32'($urandom_range(24, 0)) : 32'($urandom_range(1000, 25));
      repeat ($urandom_range(9, 1)) idle_step;
      run_action(2'($urandom), 1'($urandom), $urandom_range(3, 0));
    end
  endtask

  task automatic test_reset_midplay;
    health = 100;
    repeat (2) idle_step;
    exec = 1;
    selected = 2'b11;
    step;
    exec = 0;
    step;
    for (int k = 0; k < FT; k++) step;
    checks++;
    if ({busy, frame} !== {1'b1, 4'd1}) $display("FAIL midplay_pre {busy,frame} got %b exp %b", {busy, frame}, {1'b1, 4'd1});
    else passed++;
    #2 rst = 0;
    #1;
    checks++;
    if ({exec_status, busy, anim_id, frame, frame_tick} !== 10'b0) $display("FAIL midplay_reset got %b exp 0", {exec_status, busy, anim_id, frame, frame_tick});
    else passed++;
    repeat (3) begin
      step;
      checks++;
      if ({exec_status, busy, anim_id, frame, frame_tick} !== 10'b0) $display("FAIL midplay_hold got %b exp 0", {exec_status, busy, anim_id, frame, frame_tick});
      else passed++;
    end
    rst = 1;
    reset_model;
    repeat (14) idle_step;
  endtask

  initial begin
    test_reset;
    test_idle;
    test_action_held;
    test_action_pulse;
    test_health_menu;
    test_zero_action;
    test_back_to_back;
    test_reset_midplay;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/companion_animator.md
Name: companion_animator

Overview:
- Graphics-side responder to the companion action handshake.
- Consumes the exec/selected request produced by the companion menu logic and plays a fixed-length action animation for the selected action (feed, play, clean).
- Returns exec_status when the animation has finished; while no action is running it loops an idle or sick animation.
- Outputs an animation id and frame index to the sprite/renderer stage.

Parameters:
- CLOCK_FREQ, 125_000_000, system clock frequency in Hz.
- FRAME_TICKS, CLOCK_FREQ/8, clock cycles per animation frame (8 fps); must be ≥1.
- ACTION_FRAMES, 8, number of frames in each action animation; range 1..16.
- IDLE_FRAMES, 4, number of frames in the idle and sick loops; range 1..16.
- SICK_THRESHOLD, 25, health strictly below this selects the sick idle loop.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- exec  in  1  action request from the menu FSM (level).
- selected  in  2  action code: 01 feed, 10 play, 11 clean, 00 none.
- menu_open  in  1  menu overlay visible; pauses the idle loop.
- health  in  32  current health stat, unsigned.
- exec_status  out  1  action complete; second half of the four-phase handshake.
- busy  out  1  high while in PLAY.
- anim_id  out  3  0 idle, 1 feed, 2 play, 3 clean, 4 sick.
- frame  out  4  current frame index within anim_id.
- frame_tick  out  1  one-cycle pulse on each frame advance.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE, exec_status=0, busy=0, anim_id=0, frame=0, frame_tick=0.
  - tick counter=0, latched action=0.
  - All outputs are registered.
- Tick counter:
  - Counts 0..FRAME_TICKS-1 and wraps.
  - frame_tick=1 in the cycle after the counter held FRAME_TICKS-1.
  - Counter is cleared on every state transition, so each first frame lasts a full FRAME_TICKS.
- State IDLE:
  - anim_id = 4 if health < SICK_THRESHOLD (unsigned compare), else 0; re-evaluated every cycle.
  - On frame_tick, frame increments modulo IDLE_FRAMES.
  - If anim_id changes, frame resets to 0 in the same update.
  - menu_open=1 freezes frame and the tick counter (no frame_tick); anim_id still tracks health.
  - exec=1 and selected≠00 at an edge: latch selected and move to PLAY at the next edge. anim_id=selected, frame=0, busy=1.
  - exec=1 and selected=00: go directly to DONE (zero-length action); anim_id unchanged.
- State PLAY:
  - Lasts exactly ACTION_FRAMES*FRAME_TICKS cycles.
  - frame advances 0..ACTION_FRAMES-1 on frame_tick.
  - The frame_tick that would take frame to ACTION_FRAMES instead moves to DONE; frame holds ACTION_FRAMES-1.
  - exec and selected are ignored in PLAY; changes to selected do not alter the running animation.
  - Deasserting exec early does not abort.
  - menu_open does not pause PLAY.
- State DONE:
  - exec_status=1, busy=0; anim_id and frame hold the last action frame.
  - Remains until exec is sampled 0.
  - Then exec_status=0 at the next edge and state returns to IDLE with frame=0 and the idle/sick anim_id.
  - This completes the four-phase handshake: exec↑ → (play) → exec_status↑ → exec↓ → exec_status↓.
  - A requester that pulses exec for one cycle therefore sees exec_status for exactly one cycle after completion.
- No new request is accepted until IDLE is re-entered. exec held high through DONE never starts a second action.
- Latency: exec sampled at edge N → busy=1 after edge N+1 → exec_status=1 after edge N+1+ACTION_FRAMES*FRAME_TICKS.
- Reset asserted mid-PLAY or in DONE aborts immediately to the reset state; no exec_status is generated.

Test Plan:
- Test parameters: FRAME_TICKS=4, ACTION_FRAMES=3, IDLE_FRAMES=2, SICK_THRESHOLD=25, health=100.
- Reset, then idle for 20 cycles → anim_id=0; frame toggles 0,1,0,… every 4 cycles; frame_tick pulses every 4 cycles; exec_status=0; busy=0.
- exec=1 with selected=10, held → busy=1 and anim_id=2 one cycle later; frames 0,1,2 at 4 cycles each; exec_status=1 exactly 12 cycles after busy rises and stays high while exec=1. Drop exec → exec_status=0 next cycle, anim_id=0, frame=0.
- One-cycle exec pulse with selected=01, then change selected to 11 during PLAY → anim_id stays 1 throughout; exec_status high for exactly 1 cycle after completion.
- health stepped from 100 to 24 during IDLE → anim_id=4 and frame=0 next cycle. Set menu_open=1 for 10 cycles → frame frozen, no frame_tick. Set health back to 25 → anim_id=0.
- exec=1 with selected=00 → no PLAY, busy stays 0; exec_status=1 the next cycle until exec drops.
- Assert rst=0 in the middle of PLAY (frame=1) → all outputs 0 immediately, without a clock edge. Release rst with exec=0 → idle loop resumes, exec_status never pulses.
